// File: rtl/seqdet_stream_ctrl.sv
// -----------------------------------------------------------------------------
// seqdet_stream_ctrl
//   Byte-to-bit serializer feeding a programmable serial pattern detector.
//   Bytes arrive over a valid/ready handshake and are shifted out MSB-first,
//   one bit per clock, into a history register. A pattern of 1..8 bits is
//   matched (with or without overlap); matches are counted (saturating) and a
//   sticky interrupt fires when the count reaches a programmable threshold.
//
// Ports
//   clk, nrst            clock (rising edge), async active-low reset
//   cfg_we               config write strobe (honoured only when idle)
//   cfg_pat/len/ovl      pattern, length (0->1, >8->8), overlap enable
//   cfg_thresh           interrupt threshold, 0 disables
//   s_valid/s_ready      byte handshake
//   s_data, s_last       byte (MSB first) and end-of-frame flag
//   irq_clr              clears irq and match_cnt
//   busy                 serialization in progress
//   match_pulse          one-cycle pulse per match
//   match_cnt            saturating match count
//   frame_done           one-cycle pulse after the last bit of a frame
//   irq                  sticky threshold interrupt
// -----------------------------------------------------------------------------
module seqdet_stream_ctrl #(
  parameter int CNT_W = 8,
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_ovl,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PAT_W-1:0] s_data,
  input  logic             s_last,
  input  logic             irq_clr,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic             frame_done,
  output logic             irq
);

  localparam int IDX_W = $clog2(PAT_W);

  typedef enum logic [0:0] {IDLE, SHIFT} state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   data_q, data_d;
  logic               last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [3:0]         len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [3:0]         bv_q, bv_d;
  logic               match_pulse_q, match_pulse_d;
  logic               frame_done_q, frame_done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_q, irq_d;

  logic               hs;
  logic               cfg_ok;
  logic [PAT_W-1:0]   hist_shift;
  logic [PAT_W-1:0]   mask;
  logic [3:0]         bv_inc;
  logic               match;
  logic [CNT_W-1:0]   cnt_base;
  logic [CNT_W-1:0]   cnt_inc;
  logic [3:0]         len_clamped;

  // The next byte may be taken while the final bit of the current one shifts,
  // which is what gives back-to-back bytes with no bubble.
  assign s_ready = (state_q == IDLE) || (idx_q == '0);
  assign busy    = (state_q == SHIFT);
  assign hs      = s_valid & s_ready;
  assign cfg_ok  = cfg_we & ~busy & ~hs;

  assign match_pulse = match_pulse_q;
  assign frame_done  = frame_done_q;
  assign match_cnt   = cnt_q;
  assign irq         = irq_q;

  always_comb begin
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len_q));
  end

  assign hist_shift = {hist_q[PAT_W-2:0], data_q[idx_q]};
  assign bv_inc     = (bv_q == 4'(PAT_W)) ? bv_q : bv_q + 4'd1;
  assign match      = (state_q == SHIFT) && (bv_inc >= len_q) &&
                      (((hist_shift ^ pat_q) & mask) == '0);

  assign len_clamped = (cfg_len == 4'd0)      ? 4'd1 :
                       (cfg_len > 4'(PAT_W))  ? 4'(PAT_W) : cfg_len;

  assign cnt_base = irq_clr ? '0 : cnt_q;
  assign cnt_inc  = cnt_base + CNT_W'(1);

  always_comb begin
    // NOTE: every *_d gets a default up front so no path leaves a variable
    // unassigned; that is what keeps this block free of inferred latches.
    state_d       = state_q;
    data_d        = data_q;
    last_d        = last_q;
    idx_d         = idx_q;
    pat_d         = pat_q;
    len_d         = len_q;
    ovl_d         = ovl_q;
    thresh_d      = thresh_q;
    hist_d        = hist_q;
    bv_d          = bv_q;
    match_pulse_d = match;
    frame_done_d  = 1'b0;
    cnt_d         = cnt_base;
    irq_d         = irq_clr ? 1'b0 : irq_q;

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          data_d  = s_data;
          last_d  = s_last;
          idx_d   = IDX_W'(PAT_W - 1);
          state_d = SHIFT;
        end else if (cfg_ok) begin
          pat_d    = cfg_pat;
          len_d    = len_clamped;
          ovl_d    = cfg_ovl;
          thresh_d = cfg_thresh;
          hist_d   = '0;
          bv_d     = '0;
        end
      end
      SHIFT: begin
        hist_d = hist_shift;
        // Without overlap a match consumes its bits: the next one needs len
        // fresh bits.
        bv_d   = (match && !ovl_q) ? 4'd0 : bv_inc;
        if (idx_q == '0) begin
          // Frame end clears after bit 0 has already been compared above.
          if (last_q) begin
            hist_d       = '0;
            bv_d         = '0;
            frame_done_d = 1'b1;
          end
          if (hs) begin
            data_d = s_data;
            last_d = s_last;
            idx_d  = IDX_W'(PAT_W - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // irq_clr has already zeroed cnt_base, so a coincident match counts as 1.
    if (match && (cnt_base != '1)) begin
      cnt_d = cnt_inc;
      if ((cnt_inc == thresh_q) && (thresh_q != '0)) irq_d = 1'b1;
    end

    // A config write only happens in IDLE, where no match can occur.
    if (cfg_ok) begin
      cnt_d = '0;
      irq_d = 1'b0;
    end
  end

  // NOTE: sequential state updates use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      data_q        <= '0;
      last_q        <= 1'b0;
      idx_q         <= '0;
      pat_q         <= '0;
      len_q         <= 4'd1;
      ovl_q         <= 1'b0;
      thresh_q      <= '0;
      hist_q        <= '0;
      bv_q          <= '0;
      match_pulse_q <= 1'b0;
      frame_done_q  <= 1'b0;
      cnt_q         <= '0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      last_q        <= last_d;
      idx_q         <= idx_d;
      pat_q         <= pat_d;
      len_q         <= len_d;
      ovl_q         <= ovl_d;
      thresh_q      <= thresh_d;
      hist_q        <= hist_d;
      bv_q          <= bv_d;
      match_pulse_q <= match_pulse_d;
      frame_done_q  <= frame_done_d;
      cnt_q         <= cnt_d;
      irq_q         <= irq_d;
    end
  end

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seqdet_stream_ctrl
//   Self-checking bench for seqdet_stream_ctrl. A behavioural model keeps the
//   pending serial bits and the recently received bits as queues, matches the
//   pattern by direct comparison and counts with plain integers. Directed
//   scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_seqdet_stream_ctrl;

  localparam int CNT_W   = 8;
  localparam int PAT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             nrst;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pat;
  logic [3:0]       cfg_len;
  logic             cfg_ovl;
  logic [CNT_W-1:0] cfg_thresh;
  logic             s_valid;
  logic             s_ready;
  logic [PAT_W-1:0] s_data;
  logic             s_last;
  logic             irq_clr;
  logic             busy;
  logic             match_pulse;
  logic [CNT_W-1:0] match_cnt;
  logic             frame_done;
  logic             irq;

  seqdet_stream_ctrl #(.CNT_W(CNT_W), .PAT_W(PAT_W)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .cfg_we      (cfg_we),
    .cfg_pat     (cfg_pat),
    .cfg_len     (cfg_len),
    .cfg_ovl     (cfg_ovl),
    .cfg_thresh  (cfg_thresh),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .irq_clr     (irq_clr),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_cnt   (match_cnt),
    .frame_done  (frame_done),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  bit         bit_q[$];   // bits still to be serialized
  bit         lst_q[$];   // end-of-frame flag travelling with each bit
  bit         recent[$];  // bits seen since the last clear, oldest first
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_thresh;
  int         m_cnt;
  bit         m_irq;
  bit         last_hs;

  function automatic void model_reset();
    bit_q.delete(); lst_q.delete(); recent.delete();
    m_pat = '0; m_len = 1; m_ovl = 0; m_thresh = 0;
    m_cnt = 0; m_irq = 0;
  endfunction

  // One clock: predict, advance the edge, compare registered outputs.
  task automatic step();
    bit exp_ready, hs, cfg_acc, m_match, m_fd, b, bl, ok;
    exp_ready = (bit_q.size() <= 1);
    check("s_ready", s_ready, exp_ready);
    check("busy", busy, bit_q.size() != 0);
    hs      = s_valid && exp_ready;
    cfg_acc = cfg_we && (bit_q.size() == 0) && !hs;
    m_match = 0;
    m_fd    = 0;
    if (bit_q.size() != 0) begin
      b  = bit_q.pop_front();
      bl = lst_q.pop_front();
      recent.push_back(b);
      if (recent.size() > 8) void'(recent.pop_front());
      if (recent.size() >= m_len) begin
        ok = 1;
        for (int i = 0; i < m_len; i++)
          if (recent[recent.size() - 1 - i] != m_pat[i]) ok = 0;
        m_match = ok;
      end
      if (m_match && !m_ovl) recent.delete();
      if (bl) begin
        recent.delete();
        m_fd = 1;
      end
    end
    if (irq_clr) begin
      m_cnt = 0;
      m_irq = 0;
    end
    if (m_match && m_cnt < CNT_MAX) begin
      m_cnt++;
      if (m_cnt == m_thresh && m_thresh != 0) m_irq = 1;
    end
    if (hs)
      for (int i = 7; i >= 0; i--) begin
        bit_q.push_back(s_data[i]);
        lst_q.push_back(s_last && (i == 0));
      end
    if (cfg_acc) begin
      m_pat    = cfg_pat;
      m_len    = (cfg_len == 0) ? 1 : (cfg_len > 8) ? 8 : int'(cfg_len);
      m_ovl    = cfg_ovl;
      m_thresh = int'(cfg_thresh);
      recent.delete();
      m_cnt = 0;
      m_irq = 0;
    end
    last_hs = hs;
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
    irq_clr = 1'b0;
    check("match_pulse", match_pulse, m_match);
    check("frame_done", frame_done, m_fd);
    check("match_cnt", match_cnt, m_cnt);
    check("irq", irq, m_irq);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      step();
      n++;
    end while (!last_hs && n < 20);
    if (!last_hs) check("hs_timeout", 1, 0);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (bit_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    if (bit_q.size() != 0) check("drain_timeout", 1, 0);
    step();
  endtask

  task automatic write_cfg(input logic [7:0] p, input logic [3:0] l,
                           input logic o, input logic [7:0] t);
    drain();
    cfg_we     = 1'b1;
    cfg_pat    = p;
    cfg_len    = l;
    cfg_ovl    = o;
    cfg_thresh = t;
    step();
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #2;
    model_reset();
    check("rst_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_irq", irq, 0);
    check("rst_pulse", match_pulse, 0);
    check("rst_fd", frame_done, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", s_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_cnt", match_cnt, 0);
    check("post_rst_irq", irq, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    nrst = 1'b0; cfg_we = 0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 0;
    cfg_thresh = '0; s_valid = 0; s_data = '0; s_last = 0; irq_clr = 0;
    #7;
    do_reset();

    // Overlapping match on 0x92: pulses after E5 and E8.
    write_cfg(8'b0001_0010, 4'd5, 1'b1, 8'd0);
    send_byte(8'h92, 1'b1);
    drain();
    check("ovl_cnt", match_cnt, 2);

    // Non-overlapping: single match. A config write during SHIFT is ignored.
    write_cfg(8'b0001_0010, 4'd5, 1'b0, 8'd0);
    send_byte(8'h92, 1'b1);
    cfg_we = 1'b1; cfg_pat = 8'hFF; cfg_len = 4'd1; cfg_ovl = 1'b1;
    step();
    drain();
    check("novl_cnt", match_cnt, 1);

    // Pattern spanning a byte boundary, back-to-back bytes.
    write_cfg(8'b0001_0010, 4'd5, 1'b1, 8'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h20, 1'b0);
    drain();
    check("span_cnt", match_cnt, 1);
    // Same bytes with a frame end between them: history is cleared.
    write_cfg(8'b0001_0010, 4'd5, 1'b1, 8'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h20, 1'b1);
    drain();
    check("frame_cnt", match_cnt, 0);

    // Threshold interrupt and clear.
    write_cfg(8'h01, 4'd1, 1'b0, 8'd3);
    send_byte(8'h07, 1'b1);
    drain();
    check("thr_irq", irq, 1);
    check("thr_cnt", match_cnt, 3);
    irq_clr = 1'b1;
    step();
    check("clr_irq", irq, 0);
    check("clr_cnt", match_cnt, 0);

    // irq_clr coinciding with a match.
    write_cfg(8'h01, 4'd1, 1'b1, 8'd1);
    send_byte(8'hFF, 1'b1);
    step();
    step();
    irq_clr = 1'b1;
    step();
    check("clr_match_cnt", match_cnt, 1);
    check("clr_match_irq", irq, 1);
    drain();

    // Length clamping.
    write_cfg(8'h01, 4'd0, 1'b1, 8'd0);
    send_byte(8'h07, 1'b1);
    drain();
    check("len0_cnt", match_cnt, 3);
    write_cfg(8'hA5, 4'd12, 1'b1, 8'd0);
    send_byte(8'hA5, 1'b1);
    drain();
    check("len12_cnt", match_cnt, 1);

    // Saturation: 320 matches.
    write_cfg(8'h01, 4'd1, 1'b1, 8'd0);
    for (int i = 0; i < 40; i++) send_byte(8'hFF, 1'b0);
    drain();
    check("sat_cnt", match_cnt, CNT_MAX);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      s_last  = ($urandom_range(0, 3) == 0);
      irq_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 39) == 0) begin
        cfg_we     = 1'b1;
        cfg_pat    = 8'($urandom);
        cfg_len    = 4'($urandom_range(0, 5));
        cfg_ovl    = 1'($urandom);
        cfg_thresh = 8'($urandom_range(0, 6));
        s_valid    = ($urandom_range(0, 1) != 0);
      end
      step();
    end
    s_valid = 1'b0;

    // Reset in the middle of a byte: dropped, no pulses.
    send_byte(8'hFF, 1'b1);
    step();
    step();
    do_reset();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
